tdc_ctrl: RTL and testbench

Measurement controller between the pins, the ring-oscillator TDC and the UART byte interface. It synchronises the asynchronous start/stop pins and the ring pulse train, and enables the oscillator only while a measurement is in progress. It counts coarse system-clock cycles and fine ring pulses, then streams a fixed result frame over the valid/ready byte port that feeds the UART transmitter.

---
 rtl/tdc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_tdc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_ctrl.sv
// tdc_ctrl: measurement controller for a ring-oscillator TDC.
// Synchronises the start/stop pins and the ring pulse train, runs the
// oscillator only while measuring, counts coarse clk cycles and fine ring
// edges, then streams a fixed result frame over a valid/ready byte port.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   start, stop       asynchronous pins, rising edge starts/ends a measurement
//   ring_pulse        asynchronous ring oscillator output (< clk/2)
//   tdc_en            oscillator enable, high only while measuring
//   busy              high whenever a measurement or frame is in progress
//   axi_data/valid    frame byte and its valid flag
//   axi_ready         downstream accepts the byte
//
// Optional feature: define TDC_CTRL_CSUM_EN to append an XOR checksum byte.
module tdc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       ring_pulse,
  output logic       tdc_en,
  output logic       busy,
  output logic [7:0] axi_data,
  output logic       axi_valid,
  input  logic       axi_ready
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
`ifdef TDC_CTRL_CSUM_EN
  localparam int unsigned FRAME_LEN = 7;
`else
  localparam int unsigned FRAME_LEN = 6;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [7:0]       SYNC_BYTE   = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] start_sync, stop_sync, ring_sync;
  logic                   start_q, stop_q, ring_q;
  logic                   start_edge, stop_edge, ring_edge;

  logic [CNT_W-1:0] coarse, fine;
  logic             timeout_flag, fine_ovf;
  logic [IDX_W-1:0] idx;

  logic [CNT_W-1:0] coarse_nxt, fine_nxt, coarse_inc;
  logic             timeout_nxt, ovf_nxt, timeout_hit, xfer;
  logic [IDX_W-1:0] idx_nxt, idx_inc;
  logic [7:0]       data_nxt, byte_sel, status_byte;
  logic             valid_nxt, tdc_en_nxt, busy_nxt;

  // Input synchronisers plus one edge-detect register per input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync <= '0;
      stop_sync  <= '0;
      ring_sync  <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      ring_q     <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start};
      stop_sync  <= {stop_sync[SYNC_STAGES-2:0], stop};
      ring_sync  <= {ring_sync[SYNC_STAGES-2:0], ring_pulse};
      start_q    <= start_sync[SYNC_STAGES-1];
      stop_q     <= stop_sync[SYNC_STAGES-1];
      ring_q     <= ring_sync[SYNC_STAGES-1];
    end
  end

  assign start_edge  = start_sync[SYNC_STAGES-1] & ~start_q;
  assign stop_edge   = stop_sync[SYNC_STAGES-1] & ~stop_q;
  assign ring_edge   = ring_sync[SYNC_STAGES-1] & ~ring_q;

  assign coarse_inc  = coarse + CNT_W'(1);
  assign idx_inc     = idx + IDX_W'(1);
  assign xfer        = axi_valid & axi_ready;
  // A stop in the same cycle as the timeout wins, so timeout stays clear
  assign timeout_hit = (state == RUN) && !stop_edge && (coarse_inc == TIMEOUT_VAL);
  assign status_byte = {timeout_flag, fine_ovf, 6'b0};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_edge) state_nxt = stop_edge ? SEND : RUN;
      RUN:  if (stop_edge || (coarse_inc == TIMEOUT_VAL)) state_nxt = SEND;
      SEND: if (xfer && (idx == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte presented after the current one transfers
  always_comb begin
    byte_sel = SYNC_BYTE;
    case (idx_inc)
      3'd1: byte_sel = status_byte;
      3'd2: byte_sel = coarse[15:8];
      3'd3: byte_sel = coarse[7:0];
      3'd4: byte_sel = fine[15:8];
      3'd5: byte_sel = fine[7:0];
`ifdef TDC_CTRL_CSUM_EN
      3'd6: byte_sel = SYNC_BYTE ^ status_byte ^ coarse[15:8] ^ coarse[7:0]
                     ^ fine[15:8] ^ fine[7:0];
`endif
      default: byte_sel = SYNC_BYTE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    coarse_nxt  = coarse;
    fine_nxt    = fine;
    timeout_nxt = timeout_flag;
    ovf_nxt     = fine_ovf;
    idx_nxt     = idx;
    data_nxt    = axi_data;
    valid_nxt   = axi_valid;
    tdc_en_nxt  = (state_nxt == RUN);
    busy_nxt    = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (start_edge) begin
          coarse_nxt  = '0;
          fine_nxt    = '0;
          timeout_nxt = 1'b0;
          ovf_nxt     = 1'b0;
        end
      end
      RUN: begin
        coarse_nxt = coarse_inc;
        if (ring_edge) begin
          if (fine == CNT_MAX) ovf_nxt  = 1'b1;
          else                 fine_nxt = fine + CNT_W'(1);
        end
        if (timeout_hit) timeout_nxt = 1'b1;
      end
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            valid_nxt = 1'b0;
            idx_nxt   = '0;
          end else begin
            idx_nxt  = idx_inc;
            data_nxt = byte_sel;
          end
        end
      end
      default: ;
    endcase
    // Sync byte goes out on the first SEND cycle
    if ((state != SEND) && (state_nxt == SEND)) begin
      valid_nxt = 1'b1;
      data_nxt  = SYNC_BYTE;
      idx_nxt   = '0;
    end
  end

  // Registered outputs and measurement counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coarse       <= '0;
      fine         <= '0;
      timeout_flag <= 1'b0;
      fine_ovf     <= 1'b0;
      idx          <= '0;
      axi_data     <= '0;
      axi_valid    <= 1'b0;
      tdc_en       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coarse       <= coarse_nxt;
      fine         <= fine_nxt;
      timeout_flag <= timeout_nxt;
      fine_ovf     <= ovf_nxt;
      idx          <= idx_nxt;
      axi_data     <= data_nxt;
      axi_valid    <= valid_nxt;
      tdc_en       <= tdc_en_nxt;
      busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tdc_ctrl.sv
// tb_tdc_ctrl: directed bench for tdc_ctrl (TIMEOUT_CYCLES=200).
// Table of measurements with hand-computed frames, plus hand-written
// sequences for start-during-SEND, RUN entry latency and async resets.
module tb_tdc_ctrl;

  localparam int unsigned TIMEOUT = 200;
`ifdef TDC_CTRL_CSUM_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ring_pulse = 1'b0;
  logic       axi_ready = 1'b1;
  logic       tdc_en, busy, axi_valid;
  logic [7:0] axi_data;

  tdc_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .ring_pulse (ring_pulse),
    .tdc_en     (tdc_en),
    .busy       (busy),
    .axi_data   (axi_data),
    .axi_valid  (axi_valid),
    .axi_ready  (axi_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               stop_at;   // cycle of stop rise, -1 = never
    int               n_ring;
    int               stall_at;  // bytes transferred before a 10-cycle stall, -1 = none
    logic [5:0][7:0]  frame;
    int               en_cyc;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] got[$];
  int         total = 0;
  int         bad = 0;
  int         en_cycles = 0;
  int         stall_at = -1;
  int         stall_base = 0;
  int         stall_cnt = 0;
  logic       hold_chk = 1'b0;
  logic [7:0] hold_data = 8'h00;

  function automatic logic [5:0][7:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [7:0] b4, input logic [7:0] b5);
    logic [5:0][7:0] f;
    f[0] = b0; f[1] = b1; f[2] = b2; f[3] = b3; f[4] = b4; f[5] = b5;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample on the falling edge, then step to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      if (hold_chk) begin
        check("stall_valid", 32'(axi_valid), 32'd1);
        check("stall_data", 32'(axi_data), 32'(hold_data));
      end
      hold_chk  = axi_valid && !axi_ready;
      hold_data = axi_data;
      if (axi_valid && axi_ready) got.push_back(axi_data);
      if (tdc_en) en_cycles++;
    end else begin
      hold_chk = 1'b0;
    end
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      axi_ready = 1'b0;
      stall_cnt--;
    end else begin
      axi_ready = 1'b1;
      if (stall_at >= 0 && axi_valid && (got.size() - stall_base) == stall_at) begin
        axi_ready = 1'b0;
        stall_cnt = 9;
        stall_at  = -1;
      end
    end
  endtask

  task automatic wait_frame(input string name, input int base);
    int n = 0;
    while (!((got.size() - base) >= FL && !busy) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) begin
      total++;
      bad++;
      $display("FAIL %s_wait: frame incomplete after %0d cycles, bytes=%0d", name, n,
               got.size() - base);
    end
  endtask

  task automatic check_frame(input string name, input logic [5:0][7:0] f, input int base);
    logic [7:0] cs;
    logic [8:0] act;
    cs = 8'h00;
    check({name, "_count"}, 32'(got.size() - base), 32'(FL));
    for (int i = 0; i < 6; i++) begin
      act = (base + i < got.size()) ? {1'b0, got[base + i]} : 9'h100;
      check($sformatf("%s_b%0d", name, i), 32'(act), 32'(f[i]));
      cs = cs ^ f[i];
    end
`ifdef TDC_CTRL_CSUM_EN
    act = (base + 6 < got.size()) ? {1'b0, got[base + 6]} : 9'h100;
    check({name, "_csum"}, 32'(act), 32'(cs));
`endif
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_valid_end"}, 32'(axi_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int base, en0, horizon;
    base       = got.size();
    en0        = en_cycles;
    stall_base = base;
    stall_at   = v.stall_at;
    horizon    = ((v.stop_at >= 0) ? v.stop_at : int'(TIMEOUT)) + 12;
    for (int c = 0; c < horizon; c++) begin
      start      = (c < 10);
      stop       = (v.stop_at >= 0) && (c >= v.stop_at) && (c < v.stop_at + 10);
      ring_pulse = (c >= 5) && (c < 5 + 2 * v.n_ring) && (((c - 5) % 2) == 0);
      tick();
    end
    start = 1'b0; stop = 1'b0; ring_pulse = 1'b0;
    wait_frame(v.name, base);
    repeat (5) tick();
    check_frame(v.name, v.frame, base);
    check({v.name, "_en_cycles"}, 32'(en_cycles - en0), 32'(v.en_cyc));
  endtask

  initial begin
    int base;
    int n;
    vecs[0] = '{"basic",     100, 37, -1, mk(8'hA5, 8'h00, 8'h00, 8'h64, 8'h00, 8'h25), 100};
    vecs[1] = '{"timeout",    -1, 10, -1, mk(8'hA5, 8'h80, 8'h00, 8'hC8, 8'h00, 8'h0A), 200};
    vecs[2] = '{"backpress",  50,  5,  2, mk(8'hA5, 8'h00, 8'h00, 8'h32, 8'h00, 8'h05), 50};
    vecs[3] = '{"simul",       0,  0, -1, mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 0};
    vecs[4] = '{"short",       1,  0, -1, mk(8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00), 1};
    vecs[5] = '{"stop_wins", 200,  3, -1, mk(8'hA5, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h03), 200};

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdc_en", 32'(tdc_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(axi_valid), 32'd0);
    check("rst_data", 32'(axi_data), 32'd0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Start re-rises while the simultaneous-edge frame is being sent
    base = got.size();
    for (int c = 0; c < 40; c++) begin
      start = (c < 3) || (c >= 5);
      stop  = (c < 3);
      tick();
    end
    start = 1'b0; stop = 1'b0;
    repeat (20) tick();
    check_frame("start_in_send", mk(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), base);

    // RUN entry latency, then reset in the middle of RUN
    for (int c = 0; c < 25; c++) begin
      start = (c < 10);
      tick();
      if (c == 1) check("entry_pre", 32'(tdc_en), 32'd0);
      if (c == 2) check("entry_en", 32'(tdc_en), 32'd1);
    end
    check("run_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_run_tdc_en", 32'(tdc_en), 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Reset after byte 3 transfers, then a fresh measurement
    base = got.size();
    n = 0;
    while ((got.size() - base) < 3 && n < 100) begin
      start = (n < 10);
      stop  = (n >= 20);
      tick();
      n++;
    end
    check("rst_send_bytes", 32'(got.size() - base), 32'd3);
    rst = 1'b0;
    #1;
    check("rst_send_valid", 32'(axi_valid), 32'd0);
    check("rst_send_busy", 32'(busy), 32'd0);
    check("rst_send_tdc_en", 32'(tdc_en), 32'd0);
    start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_send_no_resume", 32'(got.size() - base), 32'd3);
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
